// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-master memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef logic master_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way round-robin picker. On a tie the master
//            that did not win last time is chosen.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  master_id_t             last_gnt,
  output logic [NUM_MASTERS-1:0] gnt
);

  // One-hot winner: a lone requester wins, a tie goes against last_gnt
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port data RAM between the core data port
//            (master 0) and the loader/debug port (master 1). Writes complete
//            at their grant; reads wait RD_LATENCY cycles for mem_rdata and
//            return it to the master that issued them.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,        // active-low, asynchronous assert
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int              LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

  arb_state_t              state;
  arb_state_t              state_nxt;
  master_id_t              last_gnt;
  master_id_t              rd_owner;
  master_id_t              winner;
  logic [LAT_W-1:0]        lat_cnt;
  logic [NUM_MASTERS-1:0]  req_vec;
  logic [NUM_MASTERS-1:0]  pick;
  logic                    grant_any;
  logic                    grant_read;

  // Requests are masked while reset is held so no grant escapes during reset
  assign req_vec = {m1_req, m0_req} & {NUM_MASTERS{rst}};
  assign winner  = pick[1];

  rr_arbiter2 u_rr (
    .req      (req_vec),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Next-state and output decode; everything idles at zero unless driven
  always_comb begin
    state_nxt  = state;
    grant_any  = 1'b0;
    grant_read = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    case (state)
      IDLE: begin
        if (|pick) begin
          grant_any = 1'b1;
          mem_en    = 1'b1;
          if (winner == 1'b0) begin
            m0_gnt    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
          end else begin
            m1_gnt    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
          end
          grant_read = ~mem_we;
          if (grant_read) state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == '0) begin
          if (rd_owner == 1'b0) begin
            m0_rvalid = 1'b1;
            m0_rdata  = mem_rdata;
          end else begin
            m1_rvalid = 1'b1;
            m1_rdata  = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any read in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Fairness history, read owner and read latency countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
      lat_cnt  <= '0;
      rd_owner <= 1'b0;
    end else begin
      if (grant_any) last_gnt <= winner;
      if (grant_read) begin
        lat_cnt  <= LAT_INIT;
        rd_owner <= winner;
      end else if (state == RD_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter: directed scenarios plus random
//            traffic, checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int RD_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_arbiter #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        idle;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [31:0] data;
  } rexp_t;

  cmd_t  cmdq0[$];
  cmd_t  cmdq1[$];
  gexp_t gq[$];
  rexp_t rq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic got0   = 1'b0;
  logic got1   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // ---------------- RAM behind the arbiter (fixed read latency) -------------
  logic [31:0] ram [16];
  logic [31:0] pipe [RD_LATENCY];
  initial for (int i = 0; i < 16; i++) ram[i] = '0;
  initial for (int i = 0; i < RD_LATENCY; i++) pipe[i] = '0;
  assign mem_rdata = pipe[RD_LATENCY-1];

  always @(posedge clk) begin
    for (int i = RD_LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    if (mem_en && !mem_we) pipe[0] <= ram[mem_addr[5:2]];
    else                   pipe[0] <= 32'hBAD0_BAD0;
    if (mem_en && mem_we) ram[mem_addr[5:2]] = merge(ram[mem_addr[5:2]], mem_wdata, mem_be);
  end

  // ---------------- Drivers: present queued commands until granted ----------
  initial begin
    logic shown0, shown1;
    shown0 = 1'b0; shown1 = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    forever begin
      @(posedge clk); #1;
      if (cmdq0.size() > 0 && (cmdq0[0].idle ? shown0 : got0)) void'(cmdq0.pop_front());
      if (cmdq1.size() > 0 && (cmdq1[0].idle ? shown1 : got1)) void'(cmdq1.pop_front());
      shown0 = 1'b0; shown1 = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
      if (cmdq0.size() > 0) begin
        if (cmdq0[0].idle) shown0 = 1'b1;
        else begin
          m0_req = 1; m0_we = cmdq0[0].we; m0_addr = cmdq0[0].addr;
          m0_wdata = cmdq0[0].wdata; m0_be = cmdq0[0].be;
        end
      end
      if (cmdq1.size() > 0) begin
        if (cmdq1[0].idle) shown1 = 1'b1;
        else begin
          m1_req = 1; m1_we = cmdq1[0].we; m1_addr = cmdq1[0].addr;
          m1_wdata = cmdq1[0].wdata; m1_be = cmdq1[0].be;
        end
      end
    end
  end

  // ---------------- Reference model: transaction level ----------------------
  // The RAM is unavailable for RD_LATENCY cycles after a read is accepted;
  // a tie goes to whichever master did not win last.
  initial begin
    logic [31:0] ref_mem [16];
    int          busy;
    logic        last;
    logic        w;
    gexp_t       g;
    rexp_t       r;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    busy = 0;
    last = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        busy = 0;
        last = 1'b1;
        rq.delete();
      end else if (busy > 0) begin
        busy--;
      end else if (m0_req || m1_req) begin
        w    = (m0_req && m1_req) ? ~last : m1_req;
        last = w;
        g.cyc   = cyc;
        g.gnt   = w ? 2'b10 : 2'b01;
        g.we    = w ? m1_we    : m0_we;
        g.addr  = w ? m1_addr  : m0_addr;
        g.wdata = w ? m1_wdata : m0_wdata;
        g.be    = w ? m1_be    : m0_be;
        gq.push_back(g);
        if (g.we) begin
          ref_mem[g.addr[5:2]] = merge(ref_mem[g.addr[5:2]], g.wdata, g.be);
        end else begin
          r.cyc  = cyc + RD_LATENCY;
          r.rv   = g.gnt;
          r.data = ref_mem[g.addr[5:2]];
          rq.push_back(r);
          busy = RD_LATENCY;
        end
      end
    end
  end

  // ---------------- Monitor: compares DUT outputs against the queues -------
  initial begin
    forever begin
      @(negedge clk); #1;
      got0 = m0_gnt;
      got1 = m1_gnt;
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk("gnt_missing", 64'(gq[0].gnt), 64'(0));
        void'(gq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk("rvalid_missing", 64'(rq[0].rv), 64'(0));
        void'(rq.pop_front());
      end
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0 || gq[0].cyc != cyc) begin
          chk("gnt_unexpected", 64'({m1_gnt, m0_gnt}), 64'(0));
        end else begin
          chk("gnt_cmd", {27'd0, m1_gnt, m0_gnt, mem_en, mem_we, mem_be},
              {27'd0, gq[0].gnt, 1'b1, gq[0].we, gq[0].be});
          chk("mem_addr", 64'(mem_addr), 64'(gq[0].addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(gq[0].wdata));
          void'(gq.pop_front());
        end
      end else begin
        chk("idle_bus", {mem_wdata, mem_addr[27:0], mem_be},
            {1'b0, mem_en, mem_we} == 3'b000 ? 64'(0) : 64'(1));
        chk("idle_en", 64'({mem_en, mem_we}), 64'(0));
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0 || rq[0].cyc != cyc) begin
          chk("rvalid_unexpected", 64'({m1_rvalid, m0_rvalid}), 64'(0));
        end else begin
          chk("rvalid_owner", 64'({m1_rvalid, m0_rvalid}), 64'(rq[0].rv));
          chk("rdata", {m1_rdata, m0_rdata},
              rq[0].rv[1] ? {rq[0].data, 32'd0} : {32'd0, rq[0].data});
          void'(rq.pop_front());
        end
      end else begin
        chk("idle_rdata", {m1_rdata, m0_rdata}, 64'(0));
      end
    end
  end

  // ---------------- Stimulus helpers ---------------------------------------
  function automatic cmd_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be);
    cmd_t c;
    c.idle = 1'b0; c.we = we; c.addr = addr; c.wdata = wd; c.be = be;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c = mk(1'($urandom_range(0, 1)),
           ($urandom() & 32'hF000_0000) | (32'($urandom_range(0, 15)) << 2),
           $urandom(), 4'($urandom_range(0, 15)));
    if ($urandom_range(0, 9) < 3) c.idle = 1'b1;
    return c;
  endfunction

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while ((cmdq0.size() > 0 || cmdq1.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_timeout: actual=%0d/%0d commands left, required=0", cmdq0.size(), cmdq1.size());
      cmdq0.delete();
      cmdq1.delete();
    end
    repeat (RD_LATENCY + 2) @(posedge clk);
  endtask

  // ---------------- Test sequence ------------------------------------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single write, then a read by m1 with a concurrent m0 request
    cmdq0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
    wait_empty(50);
    cmdq1.push_back(mk(1'b0, 32'h10, 32'h0, 4'hF));
    cmdq0.push_back(mk(1'b1, 32'h20, 32'h1234_5678, 4'hF));
    wait_empty(50);

    // Contention straight out of reset: both masters stream writes
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmdq0.push_back(mk(1'b1, 32'h4 * i, 32'hA000_0000 + i, 4'hF));
      cmdq1.push_back(mk(1'b1, 32'h20 + 32'h4 * i, 32'hB000_0000 + i, 4'hF));
    end
    @(posedge clk); #1 rst = 1'b1;
    wait_empty(50);

    // Byte-lane write then read it back; zero byte-enable write still granted
    cmdq0.push_back(mk(1'b1, 32'h24, 32'h0000_AB00, 4'h2));
    cmdq0.push_back(mk(1'b1, 32'h28, 32'hFFFF_FFFF, 4'h0));
    cmdq0.push_back(mk(1'b0, 32'h24, 32'h0, 4'h6));
    cmdq0.push_back(mk(1'b0, 32'h28, 32'h0, 4'h0));
    wait_empty(50);

    // Reset one cycle after an m0 read grant; m1 waits across the reset
    cmdq0.push_back(mk(1'b0, 32'h10, 32'h0, 4'hF));
    n = 0;
    while (!m0_gnt && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("rd_grant_seen", 64'(m0_gnt), 64'(1));
    @(posedge clk); #1 rst = 1'b0;
    cmdq1.push_back(mk(1'b1, 32'h3C, 32'hC0FF_EE00, 4'hF));
    @(posedge clk); #1 rst = 1'b1;
    wait_empty(50);

    // Idle hygiene
    repeat (10) @(posedge clk);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      cmdq0.push_back(rnd_cmd());
      cmdq1.push_back(rnd_cmd());
    end
    wait_empty(5000);
    repeat (4) @(negedge clk);
    chk("gnt_drain", 64'(gq.size()), 64'(0));
    chk("rvalid_drain", 64'(rq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing one single-port data RAM between the RV32I core data port (master 0) and a program-loader/debug port (master 1). Selects one request at a time with round-robin fairness, drives the RAM command bus, and sequences fixed-latency reads back to the winning master. Sits between the core's load/store outputs and the RAM. Reads carry the core's byte-enable lanes through unchanged.

## Interface
Parameters:
- RD_LATENCY, 1: RAM read latency in cycles, from the command cycle to the `mem_rdata` valid cycle; legal range 1..3.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low, synchronous release by the integrator
- `m0_req` / `m1_req`  in  1  request; held with its command stable until granted
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  32  byte address, passed through unchanged
- `m0_wdata` / `m1_wdata`  in  32  write data
- `m0_be` / `m1_be`  in  4  byte enables
- `m0_gnt` / `m1_gnt`  out  1  one-cycle grant pulse; command is issued to the RAM in this cycle
- `m0_rvalid` / `m1_rvalid`  out  1  one-cycle read-data-valid pulse
- `m0_rdata` / `m1_rdata`  out  32  read data, valid only while the matching `rvalid` is high
- `mem_en`  out  1  RAM command strobe
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  32  RAM address
- `mem_wdata`  out  32  RAM write data
- `mem_be`  out  4  RAM byte enables
- `mem_rdata`  in  32  RAM read data

## Operation
FSM states are IDLE and RD_WAIT.

IDLE:
- If any `req` is high, pick a winner and drive its `we`/`addr`/`wdata`/`be` onto the `mem_*` outputs combinationally.
- In the same cycle, assert `mem_en` and the winner's `gnt`.
- A write finishes at its grant. The FSM stays in IDLE, so back-to-back writes run one per cycle.
- A read loads `lat_cnt` = RD_LATENCY−1, records the winner in `rd_owner`, and moves to RD_WAIT.

RD_WAIT:
- No grants are issued and `mem_en` = 0.
- `lat_cnt` decrements each cycle.
- In the cycle `lat_cnt` = 0: assert `rvalid` for `rd_owner`, route `mem_rdata` to that master's `rdata`, and return to IDLE.

Winner selection:
- If only one master requests, that master wins.
- If both request, the master not recorded in `last_gnt` wins.
- `last_gnt` updates on every grant.

Other rules:
- Outputs are zero when idle: `mem_*` and all `rdata` = 0 when not driven.
- Holding `req` high after `gnt` counts as a new request.
- A requester must not change its command between asserting `req` and receiving `gnt`.
- `be` = 0 with `req` high is still granted and issued; the RAM ignores it.

## Timing
- Reset values: state = IDLE, `last_gnt` = 1 (master 0 wins the first tie), `lat_cnt` = 0, `rd_owner` = 0. All outputs are 0 during and after reset.
- Grant latency: 0 cycles (`req` → `gnt` in the same cycle) when idle and uncontested.
- Read: `gnt` in cycle N, `rvalid` in cycle N+RD_LATENCY, next grant at the earliest in N+RD_LATENCY+1.
- Write throughput: 1 per cycle.
- Both masters issuing continuous writes alternate m0, m1, m0, …
- A request arriving during RD_WAIT waits; it is granted in the first IDLE cycle.
- Reset asserted mid-read: the pending `rvalid` is dropped, never emitted, and the FSM is in IDLE immediately.
- Core integration: stall the core while `m0_req` is high and neither of these holds: `m0_gnt` with `m0_we`, or `m0_rvalid`.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, RD_WAIT}
  - `master_id_t` (1-bit)
  - constant `NUM_MASTERS` = 2
- One sub-module, `rr_arbiter2`: combinational two-way round-robin picker with inputs `req[1:0]` and `last_gnt`, output one-hot `gnt[1:0]`.
- `lat_cnt` width is `$clog2(RD_LATENCY)`, minimum 1.

## Test plan
1. Reset then single write: m0 write, addr 0x10, data 0xDEADBEEF, `be` 0xF → `m0_gnt` and `mem_en`/`mem_we` in the same cycle, `mem_addr` = 0x10, `m1_gnt` = 0.
2. Read with RD_LATENCY = 2: m1 read, addr 0x10 → `m1_gnt` in cycle N, `m1_rvalid` in cycle N+2 with `m1_rdata` = 0xDEADBEEF. A concurrent `m0_req` is first granted in N+3.
3. Contention: both masters continuously write for 6 cycles from reset → grants alternate m0, m1, m0, m1, m0, m1.
4. Byte write: m0 `be` = 0x2, `wdata` = 0x0000AB00 → `mem_be` = 0x2, `mem_wdata` passes through unchanged.
5. Reset mid-read: `rst` low one cycle after an m0 read grant → no `m0_rvalid` ever, all outputs 0. After release, an m1 request is granted immediately.
6. Idle hygiene: no requests for 10 cycles → `mem_en`, all `gnt`/`rvalid` = 0, and all `rdata` = 0.
